dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_lane_align.sv | 55 +++++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the RV32I data-memory responder: funct3 codes, FSM
// states and the access-size legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // One bit per funct3 value: set where that size is a legal load / store.
    localparam logic [7:0] LOAD_SIZE_OK  = 8'b0011_0111;
    localparam logic [7:0] STORE_SIZE_OK = 8'b0000_0111;

    function automatic logic size_legal(input logic we, input logic [2:0] size);
        return we ? STORE_SIZE_OK[size] : LOAD_SIZE_OK[size];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus: request fields driven by the core (master) and
// the registered response returned by the responder (slave).
interface dmem_responder_if;

    logic        dmemReq;
    logic        dmemwe;
    logic [2:0]  dmemSize;
    logic [31:0] dmemAdrs;
    logic [31:0] dmemDataStore;
    logic [31:0] dmemDataRead;
    logic        dmemReady;
    logic        dmemErr;

    modport master (
        output dmemReq, dmemwe, dmemSize, dmemAdrs, dmemDataStore,
        input  dmemDataRead, dmemReady, dmemErr
    );

    modport slave (
        input  dmemReq, dmemwe, dmemSize, dmemAdrs, dmemDataStore,
        output dmemDataRead, dmemReady, dmemErr
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// RV32I byte-lane steering. LOAD_PATH=0: byte enables and store-data lane
// replication. LOAD_PATH=1: lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter bit LOAD_PATH = 1'b0
) (
    input  logic [1:0]  lane_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/halfword, then extend (load) or replicate (store).
    always_comb begin
        byte_s = data_i[{lane_i, 3'b000} +: 8];
        half_s = lane_i[1] ? data_i[31:16] : data_i[15:0];
        be_o   = 4'b0000;
        data_o = 32'h0000_0000;
        if (LOAD_PATH) begin
            case (size_i)
                F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
                F3_H:    data_o = {{16{half_s[15]}}, half_s};
                F3_W:    data_o = data_i;
                F3_BU:   data_o = {24'h00_0000, byte_s};
                F3_HU:   data_o = {16'h0000, half_s};
                default: data_o = 32'h0000_0000;
            endcase
        end else begin
            case (size_i)
                F3_B: begin
                    be_o   = 4'b0001 << lane_i;
                    data_o = {4{data_i[7:0]}};
                end
                F3_H: begin
                    be_o   = lane_i[1] ? 4'b1100 : 4'b0011;
                    data_o = {2{data_i[15:0]}};
                end
                F3_W: begin
                    be_o   = 4'b1111;
                    data_o = data_i;
                end
                default: begin
                    be_o   = 4'b0000;
                    data_o = 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I core: one access at a time, WAIT_CYCLES
// wait states, lane-aligned loads/stores with fault flagging.
// Optional access counters are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       loadCount,
    output logic [31:0]       storeCount,
    output logic [15:0]       errCount
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    dmem_state_e state_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH];

    logic        cur_we_s;
    logic [2:0]  cur_size_s;
    logic [31:0] cur_addr_s;
    logic [31:0] off_s;
    logic [AW-1:0] idx_s;
    logic        in_range_s;
    logic        misalign_s;
    logic        fault_s;
    logic [31:0] load_data_s;
    logic [31:0] rdata_d;
    logic [31:0] st_word_s;
    logic [3:0]  st_be_s;
    logic [3:0]  ld_be_unused_s;

    // In IDLE the live request is decoded; afterwards the latched copy is.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we_s   = bus.dmemwe;
            cur_size_s = bus.dmemSize;
            cur_addr_s = bus.dmemAdrs;
        end else begin
            cur_we_s   = we_q;
            cur_size_s = size_q;
            cur_addr_s = addr_q;
        end
    end

    // Address decode, fault classification and the load result to register.
    always_comb begin
        off_s      = cur_addr_s - BASE_ADDR;
        in_range_s = ({1'b0, off_s} < SPAN);
        idx_s      = off_s[AW+1:2];
        case (cur_size_s[1:0])
            2'b01:   misalign_s = cur_addr_s[0];
            2'b10:   misalign_s = |cur_addr_s[1:0];
            default: misalign_s = 1'b0;
        endcase
        fault_s = !size_legal(cur_we_s, cur_size_s) || misalign_s || !in_range_s;
        if (cur_we_s || fault_s) begin
            rdata_d = 32'h0000_0000;
        end else begin
            rdata_d = load_data_s;
        end
    end

    dmem_lane_align #(.LOAD_PATH(1'b0)) u_store_align (
        .lane_i (off_s[1:0]),
        .size_i (size_q),
        .data_i (wdata_q),
        .be_o   (st_be_s),
        .data_o (st_word_s)
    );

    dmem_lane_align #(.LOAD_PATH(1'b1)) u_load_align (
        .lane_i (off_s[1:0]),
        .size_i (cur_size_s),
        .data_i (mem_q[idx_s]),
        .be_o   (ld_be_unused_s),
        .data_o (load_data_s)
    );

    // Access FSM; response outputs are loaded on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            case (state_q)
                IDLE: begin
                    if (bus.dmemReq) begin
                        we_q    <= bus.dmemwe;
                        size_q  <= bus.dmemSize;
                        addr_q  <= bus.dmemAdrs;
                        wdata_q <= bus.dmemDataStore;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= fault_s;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= RESP;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                        err_q   <= fault_s;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store commit on the edge that ends RESP; a faulted access writes nothing.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= st_word_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.dmemReady    = ready_q;
    assign bus.dmemErr      = err_q;
    assign bus.dmemDataRead = rdata_q;

`ifdef DMEM_STATS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [15:0] err_cnt_q;

    // Exactly one counter advances per completed response; all wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end else if (we_q) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end else begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
        end
    end

    assign loadCount  = load_cnt_q;
    assign storeCount = store_cnt_q;
    assign errCount   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (0 and 3 wait states)
// share stimulus; a byte-array reference model supplies expected responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned W0    = 0;
    localparam int unsigned W3    = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        int          acc;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q3[$];
    logic [7:0] mem_m [4*DEPTH];
    int   n_ld[2];
    int   n_st[2];
    int   n_er[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if if0();
    dmem_responder_if if3();

`ifdef DMEM_STATS_EN
    logic [31:0] ld0, st0, ld3, st3;
    logic [15:0] er0, er3;
`endif

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
`ifdef DMEM_STATS_EN
        , .loadCount(ld0), .storeCount(st0), .errCount(er0)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W3), .BASE_ADDR(BASE)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
`ifdef DMEM_STATS_EN
        , .loadCount(ld3), .storeCount(st3), .errCount(er3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: little-endian byte array, RV32I size/alignment/range rules.
    function automatic void ref_access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                                       input logic [31:0] d, output bit err, output logic [31:0] rd);
        int unsigned     n;
        longint unsigned off;
        logic [31:0]     v;
        logic [31:0]     mask;
        n   = (sz[1:0] == 2'd0) ? 1 : ((sz[1:0] == 2'd1) ? 2 : 4);
        off = {32'h0, a} - {32'h0, BASE};
        err = (sz == 3'd3) || (sz >= 3'd6) || (we && sz[2]) || (a < BASE) ||
              (off >= 64'(4 * DEPTH)) || ((a % n) != 0);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mem_m[int'(off) + i] = 8'(d >> (8 * i));
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(n); i++) v = v | (32'(mem_m[int'(off) + i]) << (8 * i));
                if (n < 4 && !sz[2]) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    if (v[8 * n - 1]) v = v | ~mask;
                end
                rd = v;
            end
        end
    endfunction

    task automatic tally(input int id, input bit we, input bit err);
        if (err) n_er[id]++;
        else if (we) n_st[id]++;
        else n_ld[id]++;
    endtask

    task automatic set_bus(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        if0.dmemwe = we; if0.dmemSize = sz; if0.dmemAdrs = a; if0.dmemDataStore = d;
        if3.dmemwe = we; if3.dmemSize = sz; if3.dmemAdrs = a; if3.dmemDataStore = d;
    endtask

    // One-cycle request to both instances; expectations queued after the accept edge.
    task automatic issue(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        bit          err;
        logic [31:0] rd;
        @(negedge clk);
        set_bus(we, sz, a, d);
        if0.dmemReq = 1'b1;
        if3.dmemReq = 1'b1;
        @(posedge clk); #1;
        if0.dmemReq = 1'b0;
        if3.dmemReq = 1'b0;
        ref_access(we, sz, a, d, err, rd);
        e.acc = cyc; e.err = err; e.data = rd;
        q0.push_back(e); tally(0, we, err);
        q3.push_back(e); tally(1, we, err);
        repeat (W3 + 2) @(posedge clk);
    endtask

    // Response monitor: ready must match a queued access, appearing WAIT_CYCLES
    // edges after accept (sampled by the core one edge later); idle outputs are 0.
    task automatic mon(input int id, input int w, input logic rdy, input logic err, input logic [31:0] rd);
        exp_t e;
        bit   empty;
        if (rdy === 1'b1) begin
            empty = (id == 0) ? (q0.size() == 0) : (q3.size() == 0);
            if (empty) begin
                chk($sformatf("unexpected_ready_dut%0d", id), 32'd1, 32'd0);
            end else begin
                if (id == 0) e = q0.pop_front();
                else e = q3.pop_front();
                chk($sformatf("latency_dut%0d", id), 32'(cyc - e.acc), 32'(w));
                chk($sformatf("err_dut%0d", id), {31'h0, err}, {31'h0, e.err});
                chk($sformatf("rdata_dut%0d", id), rd, e.data);
            end
        end else begin
            chk($sformatf("idle_ready_dut%0d", id), {31'h0, rdy}, 32'd0);
            chk($sformatf("idle_err_dut%0d", id), {31'h0, err}, 32'd0);
            chk($sformatf("idle_rdata_dut%0d", id), rd, 32'h0);
        end
    endtask

    always @(negedge clk) if (!reset) mon(0, W0, if0.dmemReady, if0.dmemErr, if0.dmemDataRead);
    always @(negedge clk) if (!reset) mon(1, W3, if3.dmemReady, if3.dmemErr, if3.dmemDataRead);

    initial begin
        exp_t        e;
        bit          err;
        logic [31:0] rd;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < 2; i++) begin n_ld[i] = 0; n_st[i] = 0; n_er[i] = 0; end
        if0.dmemReq = 1'b0; if3.dmemReq = 1'b0;
        set_bus(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk); #1;
        chk("reset_ready0", {31'h0, if0.dmemReady}, 32'd0);
        chk("reset_err0", {31'h0, if0.dmemErr}, 32'd0);
        chk("reset_rdata0", if0.dmemDataRead, 32'h0);
        chk("reset_ready3", {31'h0, if3.dmemReady}, 32'd0);
        chk("reset_err3", {31'h0, if3.dmemErr}, 32'd0);
        chk("reset_rdata3", if3.dmemDataRead, 32'h0);
`ifdef DMEM_STATS_EN
        chk("reset_loadCount", ld0, 32'd0);
        chk("reset_storeCount", st0, 32'd0);
        chk("reset_errCount", {16'h0, er0}, 32'd0);
`endif
        reset = 1'b0;

        // Give every word a known value (the array itself is never cleared).
        for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, F3_W, BASE + 32'(4 * w), $urandom());

        issue(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, F3_W, 32'h10, 32'h0);
        issue(1'b1, F3_W, 32'h10, 32'h0);
        issue(1'b1, F3_B, 32'h13, 32'h0000_0080);
        issue(1'b0, F3_B, 32'h13, 32'h0);
        issue(1'b0, F3_BU, 32'h13, 32'h0);
        issue(1'b0, F3_W, 32'h10, 32'h0);
        issue(1'b1, F3_W, 32'h20, 32'h0);
        issue(1'b1, F3_H, 32'h22, 32'h0000_1234);
        issue(1'b0, F3_H, 32'h22, 32'h0);
        issue(1'b0, F3_H, 32'h21, 32'h0);
        issue(1'b0, F3_W, 32'h20, 32'h0);
        issue(1'b1, F3_W, 32'(4 * DEPTH), 32'h1111_1111);
        issue(1'b1, 3'b011, 32'h30, 32'h2222_2222);
        issue(1'b1, F3_W, 32'h02, 32'h3333_3333);
        issue(1'b1, F3_HU, 32'h34, 32'h4444_4444);
        issue(1'b0, F3_W, 32'h00, 32'h0);
        issue(1'b0, F3_W, 32'h30, 32'h0);
        issue(1'b0, F3_W, 32'h34, 32'h0);
        issue(1'b0, F3_W, 32'(4 * DEPTH - 4), 32'h0);

        // Request held high on the 3-wait instance: second accept only once back in IDLE.
        @(negedge clk);
        set_bus(1'b0, F3_W, 32'h10, 32'h0);
        if3.dmemReq = 1'b1;
        @(posedge clk); #1;
        ref_access(1'b0, F3_W, 32'h10, 32'h0, err, rd);
        e.acc = cyc; e.err = err; e.data = rd;
        q3.push_back(e); tally(1, 1'b0, err);
        e.acc = cyc + int'(W3) + 2;
        q3.push_back(e); tally(1, 1'b0, err);
        repeat (W3 + 2) @(posedge clk); #1;
        if3.dmemReq = 1'b0;
        repeat (W3 + 2) @(posedge clk);

        // Reset during WAIT aborts the store: no response, memory keeps old word.
        @(negedge clk);
        set_bus(1'b1, F3_W, 32'h40, 32'hAAAA_5555);
        if3.dmemReq = 1'b1;
        @(posedge clk); #1;
        if3.dmemReq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin n_ld[i] = 0; n_st[i] = 0; n_er[i] = 0; end
        repeat (W3 + 4) @(posedge clk);
        issue(1'b0, F3_W, 32'h40, 32'h0);

        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom();
            else if (r == 1) a = 32'(4 * DEPTH) + $urandom_range(0, 7);
            else if (r == 2) a = 32'(4 * DEPTH) - $urandom_range(1, 4);
            else a = $urandom_range(0, 4 * DEPTH - 1);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
        end

        repeat (8) @(posedge clk); #1;
        chk("drained_q0", 32'(q0.size()), 32'd0);
        chk("drained_q3", 32'(q3.size()), 32'd0);
`ifdef DMEM_STATS_EN
        chk("loadCount0", ld0, 32'(n_ld[0]));
        chk("storeCount0", st0, 32'(n_st[0]));
        chk("errCount0", {16'h0, er0}, {16'h0, 16'(n_er[0])});
        chk("loadCount3", ld3, 32'(n_ld[1]));
        chk("storeCount3", st3, 32'(n_st[1]));
        chk("errCount3", {16'h0, er3}, {16'h0, 16'(n_er[1])});
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
